perm_theta_iter: RTL and testbench
==================================

Name: perm_theta_iter

Overview:
- Iterative Keccak-f theta step.
- Sits directly upstream of perm_rho; its output bus feeds a_rho_in.
- Computes column parities over Y_AXIS cycles, then applies the theta correction over Y_AXIS cycles, one plane (fixed y) per cycle.
- Valid/ready handshake on both sides; trades latency for a single-plane XOR datapath.

Parameters:
- X_AXIS, 5, lanes per plane (x dimension, outermost index).
- Y_AXIS, 5, planes (y dimension); also the length of each iteration phase.
- Z_AXIS, 64, lane width in bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  a_theta_in holds a valid state.
- in_ready  output  1  block can accept a state.
- a_theta_in  input  [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]  state in, indexed [x][y][z].
- out_valid  output  1  a_theta_out holds the finished theta result.
- out_ready  input  1  downstream accepts the result.
- a_theta_out  output  [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]  registered state out, same indexing.
- busy  output  1  FSM is in PARITY or APPLY.

Behaviour:
- Reset (rst_n low, takes effect asynchronously):
  - FSM goes to IDLE; state register, parity register C[X_AXIS][Z_AXIS] and plane counter cnt ($clog2(Y_AXIS) bits) clear to 0.
  - out_valid=0, busy=0, a_theta_out=0, in_ready=1 (in_ready is combinational from IDLE).
- FSM states: IDLE, PARITY, APPLY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load state register from a_theta_in, clear C, set cnt=0, go to PARITY.
- PARITY (Y_AXIS cycles):
  - Each cycle, C[x] ^= S[x][cnt] for all x.
  - cnt increments; at cnt==Y_AXIS-1, wrap cnt to 0 and go to APPLY.
- APPLY (Y_AXIS cycles):
  - D[x][z] = C[(x+X_AXIS-1)%X_AXIS][z] ^ C[(x+1)%X_AXIS][(z+Z_AXIS-1)%Z_AXIS], i.e. rotate-left by 1 of the x+1 column.
  - Each cycle, S[x][cnt] ^= D[x] for all x; C is held constant.
  - At cnt==Y_AXIS-1, go to DONE.
- DONE:
  - out_valid=1; a_theta_out = state register, stable while out_valid=1.
  - On out_valid&out_ready, go to IDLE.
- Latency: input handshake in cycle T → out_valid first high in cycle T+2*Y_AXIS+1 (T+11 at default).
- Backpressure: out_valid stays high with data held until out_ready; in_ready=0 throughout (see optional feature).
- in_valid outside IDLE is ignored; a_theta_in is sampled only on the accept edge.
- a_theta_out is driven straight from the state register; its value outside DONE is don't-care to consumers.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.
- Reset mid-operation (PARITY/APPLY/DONE): the transaction is abandoned, all values return to their reset values, and the next accepted state is processed correctly.
- Modulo indices are elaboration constants; no runtime division.

Optional Feature:
- Macro: PERM_THETA_FAST_RELOAD_EN.
- Defined:
  - in_ready = IDLE | (DONE & out_ready).
  - Simultaneous out and in handshakes in DONE load the new state and go directly to PARITY (no IDLE bubble).
  - Back-to-back throughput is one state per 2*Y_AXIS+1 cycles.
- Undefined: in_ready = IDLE only; throughput is one state per 2*Y_AXIS+2 cycles.

Test Plan:
- All-zero state, out_ready=1, accept at cycle T → out_valid=1 at T+11; a_theta_out all zero; in_ready back to 1 at T+12.
- Only A[0][0][0]=1 → output has exactly 11 bits set: [0][0][0], [1][y][0] for y=0..4, [4][y][1] for y=0..4.
- A[2][0][5]=A[2][3][5]=1 (even column parity) → output equals input exactly.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid rises and pulse in_valid with a new state → a_theta_out stable, in_ready=0, new state ignored; out_ready=1 → one transfer, then IDLE.
- Drop rst_n in APPLY cycle 3 → out_valid/busy/a_theta_out go to 0 immediately; after release, the single-bit vector above still yields the 11-bit result.
- With PERM_THETA_FAST_RELOAD_EN: in_valid and out_ready held high with two states → second accept in the same cycle as the first output handshake; outputs spaced 11 cycles apart.

Source files
------------

// File: rtl/perm_theta_iter.sv
// Iterative Keccak-f theta step: Y_AXIS cycles of column parity, then Y_AXIS cycles of plane correction.
// Optional macro PERM_THETA_FAST_RELOAD_EN lets DONE accept the next state in the same cycle as the output handshake.
module perm_theta_iter #(
  parameter int X_AXIS = 5,
  parameter int Y_AXIS = 5,
  parameter int Z_AXIS = 64
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]     a_theta_in,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]     a_theta_out,
  output logic                                          busy
);

  localparam int CNT_W = (Y_AXIS > 1) ? $clog2(Y_AXIS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Y_AXIS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PARITY = 2'd1,
    APPLY  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                                       state_r;
  state_t                                       state_nxt_s;
  logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]    st_r;
  logic [X_AXIS-1:0][Z_AXIS-1:0]                c_r;
  logic [CNT_W-1:0]                             cnt_r;
  logic [X_AXIS-1:0][Z_AXIS-1:0]                plane_s;
  logic [X_AXIS-1:0][Z_AXIS-1:0]                d_s;
  logic                                         accept_s;
  logic                                         out_fire_s;
  logic                                         cnt_last_s;

  function automatic logic [Z_AXIS-1:0] rotl1(input logic [Z_AXIS-1:0] v);
    return {v[Z_AXIS-2:0], v[Z_AXIS-1]};
  endfunction

  // Theta correction for one column: left neighbour parity XOR rotated right neighbour parity.
  function automatic logic [Z_AXIS-1:0] theta_col(input logic [Z_AXIS-1:0] c_prev,
                                                  input logic [Z_AXIS-1:0] c_next);
    return c_prev ^ rotl1(c_next);
  endfunction

`ifdef PERM_THETA_FAST_RELOAD_EN
  assign in_ready = (state_r == IDLE) | ((state_r == DONE) & out_ready);
`else
  assign in_ready = (state_r == IDLE);
`endif

  assign accept_s    = in_valid & in_ready;
  assign out_valid   = (state_r == DONE);
  assign out_fire_s  = out_valid & out_ready;
  assign busy        = (state_r == PARITY) | (state_r == APPLY);
  assign cnt_last_s  = (cnt_r == CNT_LAST);
  assign a_theta_out = st_r;

  for (genvar gx = 0; gx < X_AXIS; gx++) begin : g_d
    localparam int XP = (gx + X_AXIS - 1) % X_AXIS;
    localparam int XN = (gx + 1) % X_AXIS;
    assign d_s[gx] = theta_col(c_r[XP], c_r[XN]);
  end

  // Select plane y == cnt for every lane column.
  always_comb begin
    plane_s = '0;
    for (int x = 0; x < X_AXIS; x++) begin
      for (int y = 0; y < Y_AXIS; y++) begin
        plane_s[x] = plane_s[x] | (st_r[x][y] & {Z_AXIS{cnt_r == CNT_W'(y)}});
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = PARITY;
        else          state_nxt_s = IDLE;
      end
      PARITY: begin
        if (cnt_last_s) state_nxt_s = APPLY;
        else            state_nxt_s = PARITY;
      end
      APPLY: begin
        if (cnt_last_s) state_nxt_s = DONE;
        else            state_nxt_s = APPLY;
      end
      DONE: begin
        // accept_s can only be high here when fast reload is built in.
        if (out_fire_s) begin
          if (accept_s) state_nxt_s = PARITY;
          else          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, parity and plane-counter datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r  <= '0;
      c_r   <= '0;
      cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            st_r  <= a_theta_in;
            c_r   <= '0;
            cnt_r <= '0;
          end
        end
        PARITY: begin
          for (int x = 0; x < X_AXIS; x++) begin
            c_r[x] <= c_r[x] ^ plane_s[x];
          end
          cnt_r <= cnt_last_s ? '0 : cnt_r + CNT_ONE;
        end
        APPLY: begin
          for (int x = 0; x < X_AXIS; x++) begin
            for (int y = 0; y < Y_AXIS; y++) begin
              if (cnt_r == CNT_W'(y)) st_r[x][y] <= st_r[x][y] ^ d_s[x];
            end
          end
          cnt_r <= cnt_last_s ? '0 : cnt_r + CNT_ONE;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perm_theta_iter.sv
// Directed self-checking bench for perm_theta_iter (default parameters, hand-computed expected states).
module tb_perm_theta_iter;

  typedef logic [4:0][4:0][63:0] st_t;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  st_t  a_theta_in;
  logic out_valid;
  logic out_ready;
  st_t  a_theta_out;
  logic busy;

  int n_checks = 0;
  int n_err    = 0;

  st_t zero_st, ones_st, single_st, exp_single, wrap_st, exp_wrap, even_st;
  int  lat;

`ifdef PERM_THETA_FAST_RELOAD_EN
  localparam int SPACING = 11;
  localparam int RELOAD_GAP = 0;
`else
  localparam int SPACING = 12;
  localparam int RELOAD_GAP = 1;
`endif

  perm_theta_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_theta_in (a_theta_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a_theta_out(a_theta_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] fold(input st_t s);
    logic [63:0] f;
    f = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        f = f ^ s[x][y];
    return f;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input st_t obs, input st_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed fold=%h ones=%0d expected fold=%h ones=%0d",
             tag, fold(obs), $countones(obs), fold(exp), $countones(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input st_t v);
    int guard;
    a_theta_in = v;
    in_valid   = 1'b1;
    guard      = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    check1("accept_ready", in_ready, 1'b1);
    step();
    in_valid   = 1'b0;
    a_theta_in = ones_st;
    check1("busy_after_accept", busy, 1'b1);
    check1("in_ready_busy", in_ready, 1'b0);
  endtask

  task automatic wait_out(output int l);
    l = 0;
    while (!out_valid && l < 50) begin
      step();
      l++;
    end
  endtask

  task automatic send(input st_t v, input st_t exp, input string tag);
    int l;
    accept(v);
    wait_out(l);
    check_int({tag, "_latency"}, l, 10);
    check_state(tag, a_theta_out, exp);
    check1({tag, "_busy_done"}, busy, 1'b0);
  endtask

  initial begin
    int rise[2];
    int acc_i[2];
    int nrise, nacc, fire0;
    logic prev_ov, acc, fire;

    zero_st = '0;
    ones_st = '1;
    single_st = '0;
    single_st[0][0][0] = 1'b1;
    exp_single = '0;
    exp_single[0][0][0] = 1'b1;
    for (int y = 0; y < 5; y++) begin
      exp_single[1][y][0] = 1'b1;
      exp_single[4][y][1] = 1'b1;
    end
    wrap_st = '0;
    wrap_st[4][2][63] = 1'b1;
    exp_wrap = '0;
    exp_wrap[4][2][63] = 1'b1;
    for (int y = 0; y < 5; y++) begin
      exp_wrap[0][y][63] = 1'b1;
      exp_wrap[3][y][0]  = 1'b1;
    end
    even_st = '0;
    even_st[2][0][5] = 1'b1;
    even_st[2][3][5] = 1'b1;

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_theta_in = '0;
    #2 rst_n = 1'b0;
    #1;
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_in_ready", in_ready, 1'b1);
    check_state("rst_out", a_theta_out, zero_st);
    #9 rst_n = 1'b1;
    step();

    // All-zero state, then in_ready returns one cycle after the output handshake
    send(zero_st, zero_st, "zero");
    check1("zero_out_valid", out_valid, 1'b1);
    step();
    check1("zero_in_ready_back", in_ready, 1'b1);
    check1("zero_out_valid_drop", out_valid, 1'b0);

    send(single_st, exp_single, "single");
    step();
    send(even_st, even_st, "even_col");
    step();
    send(wrap_st, exp_wrap, "wrap");
    step();
    send(ones_st, ones_st, "all_ones");
    step();

    // Backpressure with an ignored in_valid pulse
    out_ready = 1'b0;
    send(single_st, exp_single, "bp");
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        in_valid = 1'b1;
        a_theta_in = wrap_st;
      end else begin
        in_valid = 1'b0;
      end
      step();
      check1("bp_out_valid", out_valid, 1'b1);
      check1("bp_in_ready", in_ready, 1'b0);
      check_state("bp_hold", a_theta_out, exp_single);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check1("bp_release_valid", out_valid, 1'b0);
    check1("bp_release_busy", busy, 1'b0);
    check1("bp_release_ready", in_ready, 1'b1);
    step();
    step();
    check1("bp_pulse_ignored", busy, 1'b0);
    check_state("bp_state_kept", a_theta_out, exp_single);

    // Reset in APPLY cycle 3
    accept(single_st);
    for (int i = 0; i < 7; i++) step();
    check1("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check1("mid_rst_out_valid", out_valid, 1'b0);
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_in_ready", in_ready, 1'b1);
    check_state("mid_rst_out", a_theta_out, zero_st);
    #2 rst_n = 1'b1;
    step();
    send(single_st, exp_single, "after_rst");
    step();
    check1("after_rst_idle", out_valid, 1'b0);

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    a_theta_in = single_st;
    in_valid = 1'b1;
    nrise = 0; nacc = 0; fire0 = -1; prev_ov = 1'b0;
    rise[0] = 0; rise[1] = 0; acc_i[0] = 0; acc_i[1] = 0;
    for (int i = 0; i < 60; i++) begin
      acc  = in_valid & in_ready;
      fire = out_valid & out_ready;
      if (out_valid && !prev_ov && nrise < 2) begin
        rise[nrise] = i;
        if (nrise == 0) check_state("b2b_first", a_theta_out, exp_single);
        else            check_state("b2b_second", a_theta_out, exp_wrap);
        nrise++;
      end
      if (fire && fire0 < 0) fire0 = i;
      if (acc && nacc < 2) begin
        acc_i[nacc] = i;
        nacc++;
      end
      prev_ov = out_valid;
      step();
      if (acc && nacc == 1) a_theta_in = wrap_st;
      if (acc && nacc == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check_int("b2b_accepts", nacc, 2);
    check_int("b2b_outputs", nrise, 2);
    check_int("b2b_spacing", rise[1] - rise[0], SPACING);
    check_int("b2b_reload_gap", acc_i[1] - fire0, RELOAD_GAP);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
